// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, FSM state type and byte-enable constants shared by the access unit
package mem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t WR   = 3'd1;
  localparam state_t RD   = 3'd2;
  localparam state_t CAP  = 3'd3;
  localparam state_t RESP = 3'd4;
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_B0   = 4'b1000;
  // big-endian lanes: offset 0 owns bits 31:24, so a byte lane walks down from bit 3
  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_W ? BE_ALL : size == SZ_H ? (off[1] ? BE_LO : BE_HI) : size == SZ_B ? BE_B0 >> off : BE_NONE;
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU request/response and data-memory signals of the access unit
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_we, req_size, req_uns, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_align.sv
// load_align: picks the addressed big-endian lane(s) of a memory word and extends them to 32 bits
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = 8'(word >> {~off, 3'b000});
  assign h = off[1] ? word[15:0] : word[31:16];
  assign data = size == SZ_B ? {{24{b[7] & ~uns}}, b} : size == SZ_H ? {{16{h[15] & ~uns}}, h} : word;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit between a CPU request port and a word-wide data memory
module mem_access_unit
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mem_access_unit_if.slave bus
);
  state_t      state;
  logic        we_q, uns_q, err_q, bad, acc, accept;
  logic [1:0]  size_q;
  logic [12:0] addr_q;
  logic [31:0] wdata_q, rdata_q, aligned;
  assign accept = state == IDLE && bus.req_valid;
  assign bad = bus.req_size == SZ_R || |bus.req_addr[31:13]
             || (bus.req_size == SZ_H && bus.req_addr[0])
             || (bus.req_size == SZ_W && |bus.req_addr[1:0]);
  load_align u_align (
    .word(bus.mem_rdata),
    .size(size_q),
    .off (addr_q[1:0]),
    .uns (uns_q),
    .data(aligned)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_uns;
        err_q   <= bad;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr[12:0];
        wdata_q <= bus.req_wdata;
      end
      state <= state == IDLE ? (bus.req_valid ? (bad ? RESP : bus.req_we ? WR : RD) : IDLE)
             : state == WR ? RESP : state == RD ? CAP : state == CAP ? RESP : IDLE;
      // response data only changes on the edge into RESP, so it holds between responses
      if ((accept && bad) || state == WR || state == CAP)
        rdata_q <= state == CAP ? aligned : '0;
    end
  end
  assign acc            = state == WR || state == RD;
  assign bus.req_ready  = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_err   = state == RESP && err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_en     = acc;
  assign bus.mem_we     = state == WR;
  assign bus.mem_be     = acc ? be_of(size_q, addr_q[1:0]) : BE_NONE;
  assign bus.mem_addr   = acc ? addr_q[12:2] : '0;
  assign bus.mem_wdata  = state != WR ? '0 : size_q == SZ_B ? {4{wdata_q[7:0]}}
                        : size_q == SZ_H ? {2{wdata_q[15:0]}} : wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random and directed loads/stores checked against a byte-addressed reference memory
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_access_unit_if bus();
  mem_access_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  logic [7:0]  refm [8192];
  logic [31:0] phys [2048];

  logic busy = 1'b0;
  int   k = 0, lat = 0, t_n = 1;
  logic t_we = 1'b0, t_uns = 1'b0, t_err = 1'b0;
  logic [31:0] t_addr = '0, t_wd = '0, t_wp = '0, t_rd = '0, hold = '0;
  logic [3:0]  t_be = '0;

  int cyc = 0, acc_cyc = 0, nresp = 0, seen_lat = 0;
  logic        seen_err = 1'b0;
  logic [31:0] seen_rd = '0, seen_wd = '0;
  logic [10:0] seen_wa = '0;
  logic [3:0]  seen_wbe = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic preset(input int idx, input logic [31:0] w);
    phys[idx] = w;
    for (int i = 0; i < 4; i++) refm[idx*4+i] = 8'(w >> (24 - 8*i));
  endtask

  // reference: a request is a run of n bytes at addr, big-endian, in a flat byte memory
  task automatic model_accept();
    int a;
    logic [31:0] v;
    t_we = bus.req_we; t_uns = bus.req_uns; t_addr = bus.req_addr; t_wd = bus.req_wdata;
    t_n = bus.req_size == 2'd0 ? 1 : bus.req_size == 2'd1 ? 2 : 4;
    t_err = bus.req_size == 2'd3 || t_addr >= 32'd8192 || t_addr % t_n != 0;
    a = int'(t_addr % 4);
    t_be = '0;
    if (!t_err) for (int i = 0; i < t_n; i++) t_be[3-(a+i)] = 1'b1;
    t_wp = t_n == 1 ? {4{t_wd[7:0]}} : t_n == 2 ? {2{t_wd[15:0]}} : t_wd;
    v = '0;
    if (!t_err && !t_we) begin
      for (int i = 0; i < t_n; i++) v = (v << 8) | 32'(refm[t_addr+i]);
      if (!t_uns && t_n < 4 && v[8*t_n-1]) v = v | ~((32'd1 << (8*t_n)) - 1);
    end
    t_rd = v;
    lat = t_err ? 1 : t_we ? 2 : 3;
    k = 1;
    busy = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      busy = 1'b0;
      hold = '0;
    end else if (busy) begin
      if (k == 1 && !t_err && t_we)
        for (int i = 0; i < t_n; i++) refm[t_addr+i] = 8'(t_wd >> (8*(t_n-1-i)));
      if (k == lat) busy = 1'b0;
      else begin
        k++;
        if (k == lat) hold = t_rd;
      end
    end else if (bus.req_valid) begin
      model_accept();
      if (lat == 1) hold = t_rd;
    end
  end

  initial begin : cmp
    logic acc, rsp;
    forever begin
      @(negedge clk);
      cyc++;
      acc = busy && k == 1 && !t_err;
      rsp = busy && k == lat;
      chk("req_ready", 32'(bus.req_ready), 32'(!busy));
      chk("resp_valid", 32'(bus.resp_valid), 32'(rsp));
      chk("mem_en", 32'(bus.mem_en), 32'(acc));
      chk("mem_we", 32'(bus.mem_we), 32'(acc && t_we));
      chk("mem_be", 32'(bus.mem_be), 32'(acc ? t_be : 4'd0));
      if (acc) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(t_addr[12:2]));
        if (t_we) chk("mem_wdata", bus.mem_wdata, t_wp);
      end
      if (rsp) chk("resp_err", 32'(bus.resp_err), 32'(t_err));
      chk("resp_rdata", bus.resp_rdata, hold);
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
      if (bus.mem_en && bus.mem_we) begin
        seen_wa = bus.mem_addr; seen_wbe = bus.mem_be; seen_wd = bus.mem_wdata;
      end
      if (bus.resp_valid) begin
        seen_lat = cyc - acc_cyc; seen_rd = bus.resp_rdata; seen_err = bus.resp_err;
        nresp++;
      end
    end
  end

  // data memory: writes land after the WR edge, read data appears the cycle after RD
  initial begin : memory
    logic pen, pwe;
    logic [10:0] pa;
    logic [3:0]  pbe;
    logic [31:0] pwd;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      pen = bus.mem_en; pwe = bus.mem_we; pa = bus.mem_addr; pbe = bus.mem_be; pwd = bus.mem_wdata;
      @(posedge clk);
      #1;
      if (pen && pwe) for (int j = 0; j < 4; j++) if (pbe[j]) phys[pa][8*j +: 8] = pwd[8*j +: 8];
      bus.mem_rdata = (pen && !pwe) ? phys[pa] : $urandom;
    end
  end

  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int t = 0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size; bus.req_uns = uns;
    bus.req_addr = addr; bus.req_wdata = wdata;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      t++;
      if (t > 20) break;
    end
    if (t > 20) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom); bus.req_size = 2'($urandom); bus.req_uns = 1'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
  endtask

  task automatic run(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    int n0 = nresp, t = 0;
    send(we, size, uns, addr, wdata);
    while (nresp == n0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (nresp == n0) chk("resp_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_resp(input string name, input int l, input logic e, input logic [31:0] rd);
    chk({name, "_lat"}, 32'(seen_lat), 32'(l));
    chk({name, "_err"}, 32'(seen_err), 32'(e));
    chk({name, "_rdata"}, seen_rd, rd);
  endtask

  initial begin
    int n0, t, r;
    logic [31:0] a;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_uns = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 2048; i++) preset(i, $urandom);
    preset(4, 32'h12003456);
    preset(8, 32'h7FFF8001);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    chk_resp("sw", 2, 1'b0, 32'h0);
    chk("sw_addr", 32'(seen_wa), 32'd4);
    chk("sw_be", 32'(seen_wbe), 32'hF);
    chk("sw_wdata", seen_wd, 32'hDEADBEEF);
    run(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000A5);
    chk("sb_be", 32'(seen_wbe), 32'h4);
    chk("sb_wdata", seen_wd, 32'hA5A5A5A5);
    run(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    chk_resp("lbu", 3, 1'b0, 32'h000000A5);
    run(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    chk_resp("lb", 3, 1'b0, 32'hFFFFFFA5);
    run(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    chk_resp("lh", 3, 1'b0, 32'hFFFF8001);
    run(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
    chk_resp("lhu", 3, 1'b0, 32'h00007FFF);
    run(1'b0, 2'd2, 1'b0, 32'h02, 32'h0);
    chk_resp("lw_mis", 1, 1'b1, 32'h0);
    run(1'b0, 2'd1, 1'b0, 32'h03, 32'h0);
    chk_resp("lh_odd", 1, 1'b1, 32'h0);
    run(1'b1, 2'd2, 1'b0, 32'h2000, 32'h12345678);
    chk_resp("sw_range", 1, 1'b1, 32'h0);
    run(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    chk_resp("size11", 1, 1'b1, 32'h0);

    // reset landing in the RD cycle of a load
    n0 = nresp;
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("rst_rd_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rd_en", 32'(bus.mem_en), 32'd0);
    chk("rst_rd_resp", 32'(bus.resp_valid), 32'd0);
    chk("rst_rd_rdata", bus.resp_rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_no_resp", 32'(nresp), 32'(n0));
    run(1'b1, 2'd2, 1'b0, 32'h14, 32'h0BADF00D);
    chk_resp("sw_after_rst", 2, 1'b0, 32'h0);
    chk("sw_after_rst_addr", 32'(seen_wa), 32'd5);

    // reset landing in the WR cycle must drop the write
    send(1'b1, 2'd2, 1'b0, 32'h18, 32'h11223344);
    #1 rst = 1'b1;
    #1;
    chk("rst_wr_we", 32'(bus.mem_we), 32'd0);
    chk("rst_wr_en", 32'(bus.mem_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run(1'b0, 2'd2, 1'b0, 32'h18, 32'h0);
    chk("rst_wr_dropped", seen_rd, phys[6]);

    repeat (400) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      r = $urandom_range(0, 9);
      a = r == 0 ? $urandom : r == 1 ? 32'h1FFC + $urandom_range(0, 7) : $urandom_range(0, 255);
      send(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
    end
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
